// File: rtl/i2s_master_tx.sv
// I2S master transmitter: derives BCLK/LRCLK from clk and shifts one stereo
// sample pair per frame out of a single-entry holding register.
module i2s_master_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic [DATA_WIDTH-1:0] sample_left,
  input  logic [DATA_WIDTH-1:0] sample_right,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_dacdat,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int DIV_W      = $clog2(BCLK_DIV);
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] L_END     = BIT_W'(DATA_WIDTH);
  localparam logic [BIT_W-1:0] R_START   = BIT_W'(SLOT_WIDTH);
  localparam logic [BIT_W-1:0] R_END     = BIT_W'(SLOT_WIDTH + DATA_WIDTH);

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] frame_l;
  logic [DATA_WIDTH-1:0] frame_r;
  logic [DATA_WIDTH-1:0] hold_l;
  logic [DATA_WIDTH-1:0] hold_r;
  logic                  hold_full;

  logic             div_wrap;
  logic             fall_evt;
  logic             frame_load;
  logic             accept;
  logic [BIT_W-1:0] bit_next;
  logic [BIT_W-1:0] slot_pos;
  logic             shift_l;
  logic             shift_r;
  logic             dat_next;

  assign sample_ready = ~hold_full;
  assign accept       = sample_valid & ~hold_full;

  // Slot decode for the upcoming fall event; data lags word select by one BCLK.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    div_wrap   = 1'b0;
    fall_evt   = 1'b0;
    frame_load = 1'b0;
    bit_next   = '0;
    slot_pos   = BIT_LAST;
    shift_l    = 1'b0;
    shift_r    = 1'b0;
    dat_next   = 1'b0;

    div_wrap = enable && (div_cnt == DIV_LAST);
    fall_evt = div_wrap && i2s_bclk;
    bit_next = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    slot_pos = (bit_next == '0) ? BIT_LAST : bit_next - 1'b1;

    frame_load = fall_evt && (bit_next == '0);
    shift_l    = fall_evt && (slot_pos < L_END);
    shift_r    = fall_evt && (slot_pos >= R_START) && (slot_pos < R_END);

    if (shift_l) begin
      dat_next = frame_l[DATA_WIDTH-1];
    end else if (shift_r) begin
      dat_next = frame_r[DATA_WIDTH-1];
    end
  end

  // Holding register keeps accepting while disabled; it drains only on a frame load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_l    <= sample_left;
      hold_r    <= sample_right;
    end else if (frame_load && hold_full) begin
      hold_full <= 1'b0;
    end
  end

  // Serial clock, word select and data shifter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      bit_cnt     <= BIT_LAST;
      i2s_bclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_dacdat  <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      frame_l     <= '0;
      frame_r     <= '0;
    end else if (!enable) begin
      // Parking bit_cnt at the last position makes the first fall event land on n = 0.
      div_cnt     <= '0;
      bit_cnt     <= BIT_LAST;
      i2s_bclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_dacdat  <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      if (div_wrap) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (fall_evt) begin
        bit_cnt    <= bit_next;
        i2s_lrclk  <= (bit_next >= R_START);
        i2s_dacdat <= dat_next;

        if (frame_load) begin
          frame_start <= 1'b1;
          if (hold_full) begin
            frame_l <= hold_l;
            frame_r <= hold_r;
          end else begin
            frame_l  <= '0;
            frame_r  <= '0;
            underrun <= 1'b1;
          end
        end else begin
          if (shift_l) frame_l <= frame_l << 1;
          if (shift_r) frame_r <= frame_r << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_master_tx.sv
// Bench for i2s_master_tx: table-driven sample pairs feed a scoreboard, and a
// BCLK-rising-edge receiver deserialises each frame and checks it.
module tb_i2s_master_tx;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_left = '0;
  logic [DW-1:0] sample_right = '0;
  logic          sample_ready;
  logic          i2s_bclk;
  logic          i2s_lrclk;
  logic          i2s_dacdat;
  logic          frame_start;
  logic          underrun;

  i2s_master_tx #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .BCLK_DIV(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_dacdat   (i2s_dacdat),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] left;
    logic [15:0] right;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  localparam logic [63:0] DATA_MASK = 64'h0001FFFE_0001FFFE;
  localparam logic [63:0] LR_EXP    = 64'hFFFFFFFF_00000000;

  int    n_checks = 0;
  int    n_pass = 0;
  pair_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return 64'({i2s_bclk, i2s_lrclk, i2s_dacdat, frame_start, underrun});
  endfunction

  // Receiver: samples DACDAT/LRCLK on rising BCLK; rise index r equals bit_cnt n.
  logic        prev_bclk = 1'b0;
  logic        prev_lr = 1'b0;
  logic        active = 1'b0;
  logic        ur_flag = 1'b0;
  int          r = 0;
  int          cyc = 0;
  int          last_rise = 0;
  logic [63:0] dat_v = '0;
  logic [63:0] lr_v = '0;
  logic [15:0] got_l;
  logic [15:0] got_r;
  pair_t       e;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n || !enable) begin
      active = 1'b0;
    end else begin
      if (underrun) check("underrun_with_frame_start", 64'(frame_start), 64'd1);
      if (i2s_lrclk !== prev_lr) check("lrclk_on_bclk_fall", 64'({prev_bclk, i2s_bclk}), 64'd2);
      if (frame_start) begin
        active  = 1'b1;
        r       = 0;
        ur_flag = underrun;
        dat_v   = '0;
        lr_v    = '0;
      end else if (active && i2s_bclk && !prev_bclk) begin
        dat_v[r] = i2s_dacdat;
        lr_v[r]  = i2s_lrclk;
        if (r > 0) check("bclk_period", 64'(cyc - last_rise), 64'd8);
        last_rise = cyc;
        if (r == 63) begin
          active = 1'b0;
          check("lrclk_pattern", lr_v, LR_EXP);
          if (ur_flag) begin
            check("underrun_frame_zero", dat_v, 64'd0);
          end else if (sb.size() == 0) begin
            check("frame_without_sample", 64'(sb.size()), 64'd1);
          end else begin
            e = sb.pop_front();
            for (int i = 0; i < 16; i++) begin
              got_l[15-i] = dat_v[1+i];
              got_r[15-i] = dat_v[33+i];
            end
            check("left_bits", 64'(got_l), 64'(e.l));
            check("right_bits", 64'(got_r), 64'(e.r));
            check("slot_padding_zero", dat_v & ~DATA_MASK, 64'd0);
          end
        end else begin
          r++;
        end
      end
    end
    prev_bclk = i2s_bclk;
    prev_lr   = i2s_lrclk;
  end

  task automatic wait_fs(input int bound, output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!frame_start && cnt < bound);
  endtask

  task automatic wait_drain(input int bound);
    int c = 0;
    while (sb.size() != 0 && c < bound) begin
      @(posedge clk); #1;
      c++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t  vecs[5];
  pair_t p;
  int    c;

  initial begin
    vecs[0] = '{16'hA5C3, 16'h8001, 16'b1010010111000011, 16'b1000000000000001};
    vecs[1] = '{16'h7FFF, 16'h8000, 16'b0111111111111111, 16'b1000000000000000};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'b0000000000000000, 16'b1111111111111111};
    vecs[3] = '{16'h1234, 16'hFEDC, 16'b0001001000110100, 16'b1111111011011100};
    vecs[4] = '{16'h5555, 16'hAAAA, 16'b0101010101010101, 16'b1010101010101010};

    // Reset dominates enable.
    reset_n = 1'b0;
    enable  = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("reset_outputs_zero", outs(), 64'd0);
    check("reset_ready_high", 64'(sample_ready), 64'd1);
    enable  = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_outputs_zero", outs(), 64'd0);

    // Streaming: valid held high, data changes after each accept.
    sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample_left  = vecs[i].left;
      sample_right = vecs[i].right;
      c = 0;
      while (!sample_ready && c < 1000) begin
        @(posedge clk); #1;
        c++;
      end
      if (i >= 2) check("ready_low_span", 64'(c), 64'd511);
      @(posedge clk); #1;
      p.l = vecs[i].exp_l;
      p.r = vecs[i].exp_r;
      sb.push_back(p);
      check("ready_low_after_accept", 64'(sample_ready), 64'd0);
      if (i == 0) begin
        enable = 1'b1;
        wait_fs(50, c);
        check("first_frame_start_latency", 64'(c), 64'd8);
        check("first_frame_no_underrun", 64'(underrun), 64'd0);
      end
    end
    sample_valid = 1'b0;
    wait_drain(3000);

    // Starved frames underrun every 512 cycles.
    wait_fs(700, c);
    check("underrun_frame_start_seen", 64'(frame_start), 64'd1);
    check("underrun_pulse", 64'(underrun), 64'd1);
    wait_fs(600, c);
    check("frame_period", 64'(c), 64'd512);
    check("underrun_repeat", 64'(underrun), 64'd1);

    // Accept on the same edge as the n = 0 load.
    repeat (511) @(posedge clk);
    #1;
    sample_left  = 16'hC0DE;
    sample_right = 16'h3C5A;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    check("same_edge_frame_start", 64'(frame_start), 64'd1);
    check("same_edge_underrun", 64'(underrun), 64'd1);
    check("same_edge_accepted", 64'(sample_ready), 64'd0);
    p.l = 16'hC0DE;
    p.r = 16'h3C5A;
    sb.push_back(p);
    wait_drain(1200);

    // Disable at bit 20 while BCLK is high, accept while disabled, re-enable.
    wait_fs(600, c);
    check("pre_disable_frame_start", 64'(frame_start), 64'd1);
    repeat (164) @(posedge clk);
    #1;
    check("bclk_high_at_bit20", 64'(i2s_bclk), 64'd1);
    enable = 1'b0;
    @(posedge clk); #1;
    check("disable_outputs_zero", outs(), 64'd0);
    sample_left  = 16'h0F0F;
    sample_right = 16'hF00F;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    check("accept_while_disabled", 64'(sample_ready), 64'd0);
    p.l = 16'h0F0F;
    p.r = 16'hF00F;
    sb.push_back(p);
    repeat (5) @(posedge clk);
    #1;
    check("disabled_idle_zero", outs(), 64'd0);
    enable = 1'b1;
    wait_fs(50, c);
    check("reenable_latency", 64'(c), 64'd8);
    check("reenable_no_underrun", 64'(underrun), 64'd0);
    wait_drain(1200);

    // Reset mid-frame with a sample held.
    wait_fs(600, c);
    check("pre_reset_frame_start", 64'(frame_start), 64'd1);
    repeat (84) @(posedge clk);
    #1;
    sample_left  = 16'h1111;
    sample_right = 16'h2222;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    check("held_before_reset", 64'(sample_ready), 64'd0);
    check("bclk_high_before_reset", 64'(i2s_bclk), 64'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midframe_reset_outputs", outs(), 64'd0);
    check("midframe_reset_ready", 64'(sample_ready), 64'd1);
    reset_n = 1'b1;
    wait_fs(50, c);
    check("post_reset_latency", 64'(c), 64'd8);
    check("post_reset_underrun", 64'(underrun), 64'd1);
    @(posedge clk); #1;
    check("pulses_one_cycle", 64'({frame_start, underrun}), 64'd0);
    repeat (600) @(posedge clk);
    #1;
    check("no_stray_samples", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
